// File: rtl/shift_pipe_checker_if.sv
// Bus between a pipeline-under-test harness and the shift_pipe_checker.
// Command/handshake semantics: start and stop are single-cycle commands
// sampled on the rising edge of clk. There is no ready signal. Whether a
// command was accepted shows up on busy/done after that same edge. state
// mirrors the checker FSM for debug and assertion binding.
interface shift_pipe_checker_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic             b_err;
    logic             c_err;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic             busy;
    logic             done;
    logic [1:0]       state;

    modport master (
        output start, stop, a, b, c,
        input  b_err, c_err, err_cnt, sample_cnt, busy, done, state
    );

    modport slave (
        input  start, stop, a, b, c,
        output b_err, c_err, err_cnt, sample_cnt, busy, done, state
    );
endinterface

// File: rtl/shift_pipe_checker.sv
// Response checker for a two-output shift pipeline.
// The block keeps its own history of the stimulus a. It checks b against
// a delayed one cycle and c against a delayed DEPTH cycles. It raises
// per-cycle error flags and keeps saturating counters of compare cycles
// and of cycles with a mismatch.
module shift_pipe_checker #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    shift_pipe_checker_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]       FILL_LAST = 4'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state;
    logic [WIDTH-1:0] hist [DEPTH];
    logic [3:0]       fill_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] sample_cnt;
    logic             b_err;
    logic             c_err;
    logic             b_mis;
    logic             c_mis;

    // Compares use the history as it stands before this edge's shift.
    assign b_mis = (bus.b != hist[0]);
    assign c_mis = (bus.c != hist[DEPTH-1]);

    // Single FSM. It owns the history shift register, the fill counter,
    // the error flags and both saturating counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            err_cnt    <= '0;
            sample_cnt <= '0;
            b_err      <= 1'b0;
            c_err      <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                hist[k] <= '0;
            end
        end else begin
            case (state)
                IDLE, DONE: begin
                    // start wins over a simultaneous stop here.
                    // Any stop on its own is ignored.
                    if (bus.start) begin
                        state      <= FILL;
                        fill_cnt   <= 4'd1;
                        err_cnt    <= '0;
                        sample_cnt <= '0;
                        b_err      <= 1'b0;
                        c_err      <= 1'b0;
                        hist[0]    <= bus.a;
                        for (int k = 1; k < DEPTH; k++) begin
                            hist[k] <= '0;
                        end
                    end
                end
                FILL: begin
                    if (bus.stop) begin
                        state <= DONE;
                        b_err <= 1'b0;
                        c_err <= 1'b0;
                    end else begin
                        hist[0] <= bus.a;
                        for (int k = 1; k < DEPTH; k++) begin
                            hist[k] <= hist[k-1];
                        end
                        fill_cnt <= fill_cnt + 4'd1;
                        // After DEPTH-1 fill edges, the oldest history slot
                        // holds the a value sampled on the start edge.
                        if (fill_cnt + 4'd1 == FILL_LAST) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (bus.stop) begin
                        state <= DONE;
                        b_err <= 1'b0;
                        c_err <= 1'b0;
                    end else begin
                        b_err <= b_mis;
                        c_err <= c_mis;
                        if (sample_cnt != CNT_MAX) begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                        if ((b_mis || c_mis) && (err_cnt != CNT_MAX)) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        hist[0] <= bus.a;
                        for (int k = 1; k < DEPTH; k++) begin
                            hist[k] <= hist[k-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.b_err      = b_err;
    assign bus.c_err      = c_err;
    assign bus.err_cnt    = err_cnt;
    assign bus.sample_cnt = sample_cnt;
    assign bus.busy       = (state == FILL) || (state == CHECK);
    assign bus.done       = (state == DONE);
    assign bus.state      = state;
endmodule
